// File: rtl/spi_ram_ctrl.sv
// Command decoder and single-port RAM sitting behind the SPI slave.
// Decodes {cmd, payload} words, manages write/read pointers and returns read data.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE+1:0] tx_data,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 cmd_err
);

  // state    | meaning
  // IDLE     | accepting and decoding rx words
  // RD_FETCH | registered RAM read at rd_ptr, rd_ptr advances
  // RD_SEND  | present {2'b11, rdata} with a one-cycle tx_valid
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_FETCH = 2'd1,
    RD_SEND  = 2'd2
  } state_t;

  localparam logic [ADDR_SIZE:0] DEPTH_X = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] LAST_X  = (ADDR_SIZE+1)'(MEM_DEPTH - 1);

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_ok_q, wr_ptr_ok_d;
  logic                   rd_ptr_ok_q, rd_ptr_ok_d;
  logic [ADDR_SIZE-1:0]   rdata_q, rdata_d;
  logic [ADDR_SIZE+1:0]   tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   cmd_err_q, cmd_err_d;
  logic                   mem_we;
  logic [1:0]             cmd;
  logic [ADDR_SIZE-1:0]   payload;

  logic [ADDR_SIZE-1:0]   mem [MEM_DEPTH];

  // Wrap at the last implemented word; natural overflow when the depth fills the pointer range.
  function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
    if ({1'b0, p} == LAST_X) next_ptr = '0;
    else                     next_ptr = p + 1'b1;
  endfunction

  assign cmd     = din[ADDR_SIZE+1:ADDR_SIZE];
  assign payload = din[ADDR_SIZE-1:0];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_ok_d = wr_ptr_ok_q;
    rd_ptr_ok_d = rd_ptr_ok_q;
    rdata_d     = rdata_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    cmd_err_d   = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (cmd)
            2'b00: begin
              wr_ptr_d    = payload;
              wr_ptr_ok_d = 1'b1;
            end
            2'b01: begin
              if (wr_ptr_ok_q && ({1'b0, wr_ptr_q} < DEPTH_X)) begin
                mem_we   = 1'b1;
                wr_ptr_d = next_ptr(wr_ptr_q);
              end else begin
                cmd_err_d = 1'b1;
              end
            end
            2'b10: begin
              rd_ptr_d    = payload;
              rd_ptr_ok_d = 1'b1;
            end
            default: begin
              if (rd_ptr_ok_q) state_d   = RD_FETCH;
              else             cmd_err_d = 1'b1;
            end
          endcase
        end
      end
      RD_FETCH: begin
        // Words arriving mid-read are dropped and flagged, never decoded.
        cmd_err_d = rx_valid;
        rdata_d   = ({1'b0, rd_ptr_q} < DEPTH_X) ? mem[rd_ptr_q] : '0;
        rd_ptr_d  = next_ptr(rd_ptr_q);
        state_d   = RD_SEND;
      end
      RD_SEND: begin
        cmd_err_d  = rx_valid;
        tx_data_d  = {2'b11, rdata_q};
        tx_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_ok_q <= 1'b0;
      rd_ptr_ok_q <= 1'b0;
      rdata_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_ok_q <= wr_ptr_ok_d;
      rd_ptr_ok_q <= rd_ptr_ok_d;
      rdata_q     <= rdata_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[wr_ptr_q] <= payload;
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: full-depth and 200-word instances,
// read responses tracked through a scoreboard queue with expected cycle.
module tb_spi_ram_ctrl;

  typedef struct {
    logic [9:0] data;
    int         cyc;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic [9:0] din, din2;
  logic       rx_valid, rx_valid2;
  logic [9:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       busy, busy2;
  logic       cmd_err, cmd_err2;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q1[$];
  exp_t q2[$];

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .CLK(CLK), .RST(RST), .din(din), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .cmd_err(cmd_err)
  );

  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut200 (
    .CLK(CLK), .RST(RST), .din(din2), .rx_valid(rx_valid2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .busy(busy2), .cmd_err(cmd_err2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: every tx_valid must match the oldest pending read, data and cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (tx_valid === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx dut256: got tx_data=%h, no read pending", tx_data);
      end else begin
        e = q1.pop_front();
        if (tx_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL tx_resp dut256: got %h at cycle %0d, expected %h at cycle %0d",
                   tx_data, cyc, e.data, e.cyc);
        end
      end
    end
    if (tx_valid2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx dut200: got tx_data=%h, no read pending", tx_data2);
      end else begin
        e = q2.pop_front();
        if (tx_data2 !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL tx_resp dut200: got %h at cycle %0d, expected %h at cycle %0d",
                   tx_data2, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input bit d2, input logic [9:0] w, output logic err);
    @(negedge CLK);
    if (d2) begin din2 = w; rx_valid2 = 1'b1; end
    else    begin din  = w; rx_valid  = 1'b1; end
    @(posedge CLK);
    #1;
    err = d2 ? cmd_err2 : cmd_err;
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
  endtask

  task automatic cmd(input bit d2, input logic [9:0] w, input logic exp_err, input string name);
    logic err;
    send(d2, w, err);
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s: cmd_err=%b expected %b (word %h)", name, err, exp_err, w);
    end
  endtask

  // RD_DATA with a known expected response; returns with the DUT idle again.
  task automatic rd(input bit d2, input logic [9:0] exp_data, input string name);
    logic err;
    exp_t e;
    send(d2, 10'h300, err);
    checks++;
    if (err !== 1'b0 || (d2 ? busy2 : busy) !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: cmd_err=%b busy=%b expected 0/1", name, err, d2 ? busy2 : busy);
    end
    e.data = exp_data;
    e.cyc  = cyc + 2;
    if (d2) q2.push_back(e);
    else    q1.push_back(e);
    idle(2);
  endtask

  task automatic test_reset;
    RST = 1'b0; din = '0; din2 = '0; rx_valid = 1'b0; rx_valid2 = 1'b0;
    idle(3);
    checks++;
    if ({tx_data, tx_valid, busy, cmd_err} !== 13'h0 ||
        {tx_data2, tx_valid2, busy2, cmd_err2} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: %h/%b/%b/%b expected all 0", tx_data, tx_valid, busy, cmd_err);
    end
    @(negedge CLK) RST = 1'b1;
    cmd(0, 10'h300, 1'b1, "rd_before_addr");
    cmd(0, 10'h155, 1'b1, "wr_before_addr");
  endtask

  task automatic test_basic;
    cmd(0, 10'h012, 1'b0, "wr_addr");
    cmd(0, 10'h1A5, 1'b0, "wr_data0");
    cmd(0, 10'h1B6, 1'b0, "wr_data1");
    cmd(0, 10'h212, 1'b0, "rd_addr");
    rd(0, 10'h3A5, "basic_rd0");
    rd(0, 10'h3B6, "basic_rd1");
  endtask

  task automatic test_wrap256;
    cmd(0, 10'h0FF, 1'b0, "wrap_wr_addr");
    cmd(0, 10'h111, 1'b0, "wrap_wr_ff");
    cmd(0, 10'h122, 1'b0, "wrap_wr_00");
    cmd(0, 10'h2FF, 1'b0, "wrap_rd_addr");
    rd(0, 10'h311, "wrap_rd_ff");
    rd(0, 10'h322, "wrap_rd_00");
  endtask

  task automatic test_busy_drop;
    logic err;
    exp_t e;
    cmd(0, 10'h040, 1'b0, "drop_wr_addr");
    cmd(0, 10'h199, 1'b0, "drop_wr40");
    cmd(0, 10'h15A, 1'b0, "drop_wr41");
    cmd(0, 10'h041, 1'b0, "drop_wr_addr41");
    cmd(0, 10'h240, 1'b0, "drop_rd_addr");
    send(0, 10'h300, err);
    e.data = 10'h399;
    e.cyc  = cyc + 2;
    q1.push_back(e);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL drop_accept: busy=%b cmd_err=%b expected 1/0", busy, err);
    end
    cmd(0, 10'h177, 1'b1, "drop_word_err");
    idle(2);
    rd(0, 10'h35A, "drop_no_write");
  endtask

  task automatic test_depth200;
    cmd(1, 10'h0C8, 1'b0, "d200_wr_addr_oob");
    cmd(1, 10'h155, 1'b1, "d200_wr_oob");
    cmd(1, 10'h2C8, 1'b0, "d200_rd_addr_oob");
    rd(1, 10'h300, "d200_rd_oob");
    cmd(1, 10'h0C7, 1'b0, "d200_wr_addr_last");
    cmd(1, 10'h166, 1'b0, "d200_wr_last");
    cmd(1, 10'h167, 1'b0, "d200_wr_wrap");
    cmd(1, 10'h2C7, 1'b0, "d200_rd_addr_last");
    rd(1, 10'h366, "d200_rd_last");
    rd(1, 10'h367, "d200_rd_wrap");
    idle(2);
  endtask

  task automatic test_reset_mid_read;
    logic err;
    cmd(0, 10'h010, 1'b0, "rst_wr_addr");
    cmd(0, 10'h1C3, 1'b0, "rst_wr_data");
    cmd(0, 10'h210, 1'b0, "rst_rd_addr");
    send(0, 10'h300, err);
    RST = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_valid, busy, cmd_err} !== 13'h0) begin
      errors++;
      $display("FAIL rst_mid_read: %h/%b/%b/%b expected all 0", tx_data, tx_valid, busy, cmd_err);
    end
    idle(3);
    @(negedge CLK) RST = 1'b1;
    cmd(0, 10'h300, 1'b1, "rst_rd_ptr_cleared");
    cmd(0, 10'h210, 1'b0, "rst_rd_addr2");
    rd(0, 10'h3C3, "rst_readback");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap256;
    test_busy_drop;
    test_depth200;
    test_reset_mid_read;
    idle(4);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: pending dut256=%0d dut200=%0d expected 0", q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
